fetch_unit: RTL and testbench

Instruction-fetch front end that owns the program counter and issues in-order requests to instruction memory over a request/grant/response handshake. Returned instructions are buffered, each with its PC, in a small queue. The queue feeds the ID stage through a valid/ready handshake. A taken branch or jump resolved downstream redirects the PC and squashes all younger fetches. The block sits directly upstream of the IF/ID boundary; the decode stage consumes its outputs.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared constants for the CPU front end (address width, reset PC,
//            instruction width, NOP encoding, PC increment).
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int                 DEF_ADDR_W   = 32;
    localparam logic [31:0]        DEF_RESET_PC = 32'h0000_0000;
    localparam int                 INSTR_W      = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0]        PC_INC       = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Registered synchronous FIFO with push/pop/flush, occupancy count,
//            full and empty flags. Push while full is accepted if a pop occurs.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch front end: owns the PC, issues credit-limited
//            in-order memory requests and queues {pc, instr} for decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int                DEPTH    = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               id_valid_o,
    input  logic               id_ready_i,
    output logic [INSTR_W-1:0] id_instr_o,
    output logic [ADDR_W-1:0]  id_pc_o,
    output logic [ADDR_W-1:0]  id_pc_plus4_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    // Fetches squashed by a redirect stay outstanding on top of the live
    // ones, so the in-flight counters get extra headroom.
    localparam int OUT_W = CNT_W + 2;
    localparam int Q_W   = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0]  r_pc;
    logic [OUT_W-1:0]   r_outstanding;
    logic [OUT_W-1:0]   r_drop;

    logic [OUT_W-1:0]   w_out_next;
    logic [OUT_W:0]     w_used;
    logic               w_req;
    logic               w_gnt;
    logic               w_rsp;
    logic               w_rsp_keep;
    logic               w_q_push;
    logic               w_q_pop;
    logic [Q_W-1:0]     w_q_rdata;
    logic [CNT_W-1:0]   w_q_count;
    logic               w_q_full;
    logic               w_q_empty;
    logic [ADDR_W-1:0]  w_af_rdata;
    logic [CNT_W-1:0]   w_af_count;
    logic               w_af_full;
    logic               w_af_empty;
    logic               w_unused_ok;

    // Live credit use: queued entries plus in-flight fetches not being dropped.
    assign w_used     = (OUT_W + 1)'(w_q_count) + (OUT_W + 1)'(r_outstanding - r_drop);
    assign w_req      = !rst_i && (w_used < (OUT_W + 1)'(DEPTH));
    assign w_gnt      = w_req && imem_gnt_i;
    assign w_rsp      = imem_rvalid_i && (r_outstanding != '0);
    assign w_rsp_keep = w_rsp && (r_drop == '0);
    assign w_q_push   = w_rsp_keep && !redirect_i;
    assign w_q_pop    = id_valid_o && id_ready_i;
    assign w_out_next = r_outstanding + OUT_W'(w_gnt) - OUT_W'(w_rsp);

    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_pc;
    assign id_valid_o    = !rst_i && !w_q_empty;
    assign id_pc_o       = w_q_rdata[Q_W-1:INSTR_W];
    assign id_instr_o    = id_valid_o ? w_q_rdata[INSTR_W-1:0] : NOP_INSTR;
    assign id_pc_plus4_o = id_pc_o + ADDR_W'(PC_INC);

    assign w_unused_ok = ^{w_q_full, w_af_count, w_af_full, w_af_empty};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect_i) begin
                r_pc   <= redirect_pc_i;
                r_drop <= w_out_next;
            end else begin
                if (w_gnt) begin
                    r_pc <= r_pc + ADDR_W'(PC_INC);
                end
                if (w_rsp && (r_drop != '0)) begin
                    r_drop <= r_drop - 1'b1;
                end
            end
        end
    end

    // Addresses of live in-flight fetches; squashed fetches never enter it.
    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_addr_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_gnt && !redirect_i),
        .i_wdata (r_pc),
        .i_pop   (w_rsp_keep),
        .i_flush (redirect_i),
        .o_rdata (w_af_rdata),
        .o_count (w_af_count),
        .o_full  (w_af_full),
        .o_empty (w_af_empty)
    );

    fetch_fifo #(
        .WIDTH (Q_W),
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_q_push),
        .i_wdata ({w_af_rdata, imem_rdata_i}),
        .i_pop   (w_q_pop),
        .i_flush (redirect_i),
        .o_rdata (w_q_rdata),
        .o_count (w_q_count),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Scoreboard bench for fetch_unit with a configurable-latency
//            instruction memory that returns the fetch address as data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b0;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_plus4_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gnt_delay = 0;
    int rlat      = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t        mem_q[$];
    logic [31:0] exp_q[$];

    fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_pc_plus4_o (id_pc_plus4_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: grants after gnt_delay waiting cycles, answers rlat cycles later.
    int          wait_cnt   = 0;
    bit          waiting    = 1'b0;
    bit          redir_prev = 1'b0;
    logic [31:0] held_addr  = '0;

    always @(negedge clk_i) begin
        #1;
        cyc++;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_q[0].addr;
            void'(mem_q.pop_front());
        end
        imem_gnt_i = 1'b0;
        if (imem_req_o) begin
            if (waiting && !redir_prev) chk("addr_stable", imem_addr_o, held_addr);
            if (wait_cnt >= gnt_delay) begin
                imem_gnt_i = 1'b1;
                mem_q.push_back('{imem_addr_o, cyc + rlat});
                wait_cnt = 0;
                waiting  = 1'b0;
            end else begin
                wait_cnt++;
                waiting   = 1'b1;
                held_addr = imem_addr_o;
            end
        end else begin
            if (waiting && !rst_i && !redir_prev) chk("req_held", 32'(imem_req_o), 32'd1);
            wait_cnt = 0;
            waiting  = 1'b0;
        end
        redir_prev = redirect_i;
    end

    // Monitor: every accepted head is checked against the scoreboard.
    always @(negedge clk_i) begin
        #2;
        if (!rst_i && id_valid_o && id_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop_pc", id_pc_o, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("id_pc", id_pc_o, e);
                chk("id_instr", id_instr_o, e);
                chk("id_pc_plus4", id_pc_plus4_o, e + 32'd4);
            end
        end else if (!rst_i && !id_valid_o) begin
            chk("nop_when_invalid", id_instr_o, 32'h0);
        end
    end

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_i);
        rst_i = 1'b1;
        exp_q.delete();
        repeat (n - 1) @(negedge clk_i);
        #2;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(id_valid_o), 32'd0);
        @(negedge clk_i);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int grants;

        // 1: streaming with 1-cycle memory
        gnt_delay = 0; rlat = 1; id_ready_i = 1'b1;
        do_reset(6);
        for (int i = 0; i < 12; i++) exp_q.push_back(32'(i * 4));
        rst_i = 1'b0;
        #2;
        chk("t1_first_req", 32'(imem_req_o), 32'd1);
        chk("t1_first_addr", imem_addr_o, 32'h0);
        chk("t1_valid_c0", 32'(id_valid_o), 32'd0);
        step(); #2;
        chk("t1_valid_c1", 32'(id_valid_o), 32'd0);
        step(); #2;
        chk("t1_valid_c2", 32'(id_valid_o), 32'd1);
        wait_drain(100);
        id_ready_i = 1'b0;

        // 2: back-pressure fills the queue, then drains in order
        do_reset(6);
        rst_i = 1'b0;
        grants = 0;
        repeat (6) begin
            #2;
            if (imem_req_o && imem_gnt_i) grants++;
            step();
        end
        #2;
        chk("t2_grants", 32'(grants), 32'd2);
        chk("t2_req_off", 32'(imem_req_o), 32'd0);
        chk("t2_head_pc", id_pc_o, 32'h0);
        step();
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
        id_ready_i = 1'b1;
        wait_drain(100);
        id_ready_i = 1'b0;

        // 3: slow grant and long response latency
        gnt_delay = 3; rlat = 4;
        do_reset(6);
        for (int i = 0; i < 20; i++) exp_q.push_back(32'(i * 4));
        id_ready_i = 1'b1;
        rst_i = 1'b0;
        wait_drain(600);
        id_ready_i = 1'b0;
        gnt_delay = 0;

        // 4: redirect with two fetches in flight
        rlat = 3;
        do_reset(6);
        rst_i = 1'b0;
        step();
        step();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
        #2;
        chk("t4_req_blocked", 32'(imem_req_o), 32'd0);
        step();
        redirect_i = 1'b0;
        #2;
        chk("t4_valid_after", 32'(id_valid_o), 32'd0);
        chk("t4_req_after", 32'(imem_req_o), 32'd1);
        chk("t4_addr_after", imem_addr_o, 32'h0000_0100);
        step();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(i * 4));
        id_ready_i = 1'b1;
        wait_drain(200);
        id_ready_i = 1'b0;

        // 5: redirect coinciding with a grant and a response
        rlat = 1; id_ready_i = 1'b1;
        do_reset(6);
        rst_i = 1'b0;
        step();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h200 + 32'(i * 4));
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        #2;
        chk("t5_req_with_redirect", 32'(imem_req_o), 32'd1);
        step();
        redirect_i = 1'b0;
        #2;
        chk("t5_valid_after", 32'(id_valid_o), 32'd0);
        wait_drain(200);
        id_ready_i = 1'b0;

        // 6: reset mid-stream with fetches in flight
        rlat = 3; id_ready_i = 1'b1;
        do_reset(6);
        rst_i = 1'b0;
        step();
        step();
        rst_i = 1'b1;
        #2;
        chk("t6_rst_req", 32'(imem_req_o), 32'd0);
        chk("t6_rst_valid", 32'(id_valid_o), 32'd0);
        step();
        step();
        rst_i = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        #2;
        chk("t6_restart_req", 32'(imem_req_o), 32'd1);
        chk("t6_restart_addr", imem_addr_o, 32'h0);
        wait_drain(200);
        id_ready_i = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
